taus_seq: RTL
=============

TAUS_SEQ -- requirements
Module: taus_seq

Interface
REQ-001 SHALL have parameter DEF_S0, default 32'd4660, substitute seed for s0.
REQ-002 SHALL have parameter DEF_S1, default 32'd22136, substitute seed for s1.
REQ-003 SHALL have parameter DEF_S2, default 32'd39612, substitute seed for s2.
REQ-004 SHALL have parameter CNT_W, default 16, burst and sample counter width.
REQ-005 SHALL have port clk, in, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port rst, in, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports seed_valid in 1, seed_ready out 1, seed0/seed1/seed2 in 32 each: seed load handshake.
REQ-008 SHALL have ports start in 1, stop in 1, burst_len in CNT_W: run control (burst_len 0 = continuous).
REQ-009 SHALL have ports taus_seed0/taus_seed1/taus_seed2 out 32 each, taus_load out 1, taus_adv out 1, taus_out in 32: generator control.
REQ-010 SHALL have ports u_data out 32, u_valid out 1, u_ready in 1: uniform sample stream.
REQ-011 SHALL have ports busy out 1, done out 1, seed_fixed out 1, sample_cnt out CNT_W: status.

Function
REQ-012 Generator contract: taus_load high latches taus_seed*; taus_adv high advances state; taus_out valid the cycle after either.
REQ-013 FSM states IDLE (unseeded), LOAD, READY (seeded), RUN, DRAIN.
REQ-014 seed_ready = 1 only in IDLE and READY; capture seeds on seed_valid && seed_ready; next state LOAD.
REQ-015 Seed validation at capture: seed0<2 -> DEF_S0, seed1<8 -> DEF_S1, seed2<16 -> DEF_S2; seed_fixed set if any substitution, else cleared; held until next capture.
REQ-016 taus_seed* driven continuously from captured seed registers.
REQ-017 LOAD lasts exactly one cycle with taus_load=1; next state READY.
REQ-018 start in READY: sample burst_len, clear sample_cnt and issue count, go RUN; start in any other state ignored.
REQ-019 RUN issue condition: (!u_valid || u_ready) && (burst_len==0 || issued<burst_len) && !stop.
REQ-020 On issue: u_data <= taus_out, u_valid <= 1, taus_adv=1 same cycle, sample_cnt += 1; one sample per cycle sustained with u_ready=1.
REQ-021 u_valid && !u_ready: u_data stable, taus_adv=0, no sample dropped or duplicated.
REQ-022 u_valid cleared on u_valid && u_ready handshake when no new issue in that cycle.
REQ-023 RUN -> DRAIN on the edge where the issue makes issued==burst_len (nonzero burst), or when stop=1 (no issue that cycle).
REQ-024 DRAIN: no issues; DRAIN -> READY on edge where u_valid==0; done=1 for exactly the first READY cycle.
REQ-025 Generator state NOT reseeded after burst; next start continues sequence.
REQ-026 Continuous mode: sample_cnt wraps modulo 2^CNT_W; burst mode count never exceeds burst_len.
REQ-027 busy = 1 in LOAD, RUN, DRAIN; taus_load and taus_adv never high in same cycle.

Reset
REQ-028 rst low: state IDLE immediately; u_valid, taus_load, taus_adv, done, busy, seed_fixed, sample_cnt = 0; u_data = 0.
REQ-029 rst low: seed registers and taus_seed* = DEF_S0/DEF_S1/DEF_S2; seed_ready=1 after release.
REQ-030 Reset mid-RUN discards pending sample; start ignored until a new seed capture.

Verification
REQ-031 Seeds 12345/12345/12345 accepted -> taus_load one cycle, taus_seed* = 12345, seed_fixed=0, state READY.
REQ-032 Seeds 1/5/100 -> taus_seed0=4660, taus_seed1=22136, taus_seed2=100, seed_fixed=1.
REQ-033 burst_len=4, u_ready=1 -> 4 back-to-back beats matching reference model, sample_cnt=4, done pulse one cycle after last beat consumed.
REQ-034 u_ready low 3 cycles mid-burst -> u_data stable, taus_adv=0 during stall, sequence intact afterward.
REQ-035 burst_len=0, stop after 10 issues -> no further issues, pending beat delivered, done, sample_cnt=10.
REQ-036 rst low mid-RUN -> u_valid=0 same cycle, state IDLE, start ignored until reseed.

Source files
------------

// File: rtl/taus_seq.sv
// taus_seq -- sequencer for an external three-component Tausworthe generator.
//
// Captures and sanitises a seed triple, loads it into the generator, then
// streams uniform samples out over a valid/ready interface. A burst is either
// a fixed length or continuous until stop. The generator is never reseeded
// between bursts, so consecutive bursts continue one sequence.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   seed_valid/seed_ready    seed load handshake, seed0..seed2 payload
//   start, stop, burst_len   run control (burst_len 0 = continuous)
//   taus_seed0..2            seed triple presented to the generator
//   taus_load, taus_adv      generator load / advance strobes
//   taus_out                 generator output, valid the cycle after a strobe
//   u_data/u_valid/u_ready   uniform sample stream
//   busy, done, seed_fixed   status flags
//   sample_cnt               samples issued in the current run
module taus_seq #(
    parameter logic [31:0] DEF_S0 = 32'd4660,
    parameter logic [31:0] DEF_S1 = 32'd22136,
    parameter logic [31:0] DEF_S2 = 32'd39612,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [31:0]      seed0,
    input  logic [31:0]      seed1,
    input  logic [31:0]      seed2,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] burst_len,
    output logic [31:0]      taus_seed0,
    output logic [31:0]      taus_seed1,
    output logic [31:0]      taus_seed2,
    output logic             taus_load,
    output logic             taus_adv,
    input  logic [31:0]      taus_out,
    output logic [31:0]      u_data,
    output logic             u_valid,
    input  logic             u_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_fixed,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_next;
    logic [31:0]      r_s0, r_s1, r_s2;
    logic             r_fixed;
    logic [31:0]      r_u_data;
    logic             r_u_valid;
    logic [CNT_W-1:0] r_cnt, r_issued, r_burst;
    logic             r_done;

    logic             w_cap, w_issue, w_last, w_start;
    logic             w_fix0, w_fix1, w_fix2;

    assign w_cap   = seed_valid && seed_ready;
    assign w_start = (r_state == S_READY) && !w_cap && start;

    // Seeds below these limits would leave a Tausworthe component stuck.
    assign w_fix0 = seed0 < 32'd2;
    assign w_fix1 = seed1 < 32'd8;
    assign w_fix2 = seed2 < 32'd16;

    // Issue only when the output slot is free (or being emptied this cycle).
    assign w_issue = (r_state == S_RUN) && (!r_u_valid || u_ready) &&
                     (r_burst == '0 || r_issued < r_burst) && !stop;
    assign w_last  = w_issue && (r_burst != '0) && (r_issued + ONE == r_burst);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cap) w_next = S_LOAD;
            S_LOAD:  w_next = S_READY;
            S_READY: begin
                if (w_cap)      w_next = S_LOAD;
                else if (start) w_next = S_RUN;
            end
            S_RUN:   if (w_last || stop) w_next = S_DRAIN;
            S_DRAIN: if (!r_u_valid) w_next = S_READY;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_s0      <= DEF_S0;
            r_s1      <= DEF_S1;
            r_s2      <= DEF_S2;
            r_fixed   <= 1'b0;
            r_u_data  <= '0;
            r_u_valid <= 1'b0;
            r_cnt     <= '0;
            r_issued  <= '0;
            r_burst   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            // done marks only the READY cycle entered from DRAIN.
            r_done  <= (r_state == S_DRAIN) && !r_u_valid;

            if (w_cap) begin
                r_s0    <= w_fix0 ? DEF_S0 : seed0;
                r_s1    <= w_fix1 ? DEF_S1 : seed1;
                r_s2    <= w_fix2 ? DEF_S2 : seed2;
                r_fixed <= w_fix0 || w_fix1 || w_fix2;
            end

            if (w_start) begin
                r_burst  <= burst_len;
                r_cnt    <= '0;
                r_issued <= '0;
            end

            if (w_issue) begin
                r_u_data  <= taus_out;
                r_u_valid <= 1'b1;
                r_cnt     <= r_cnt + ONE;
                r_issued  <= r_issued + ONE;
            end else if (r_u_valid && u_ready) begin
                r_u_valid <= 1'b0;
            end
        end
    end

    assign seed_ready = (r_state == S_IDLE) || (r_state == S_READY);
    assign busy       = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign taus_load  = (r_state == S_LOAD);
    assign taus_adv   = w_issue;
    assign taus_seed0 = r_s0;
    assign taus_seed1 = r_s1;
    assign taus_seed2 = r_s2;
    assign u_data     = r_u_data;
    assign u_valid    = r_u_valid;
    assign done       = r_done;
    assign seed_fixed = r_fixed;
    assign sample_cnt = r_cnt;

endmodule
